// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer and its datapath:
// state encoding, opcode values, ALU operand/operation encodings and an
// opcode legality helper.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_MUL    = 4'd11
    } state_t;

    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_RTYPE = 4'b0110;
    localparam logic [3:0] OP_MUL   = 4'b1000;

    localparam logic [1:0] ALUB_RT  = 2'b00;
    localparam logic [1:0] ALUB_TWO = 2'b01;
    localparam logic [1:0] ALUB_IMM = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_MUL   = 2'b11;

    // True when the opcode names an instruction this build can execute.
    function automatic logic opcode_legal(input logic [3:0] op, input logic mul_en);
        logic legal;
        case (op)
            OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ, OP_RTYPE: legal = 1'b1;
            OP_MUL:                                       legal = mul_en;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/cpu_wait_timer.sv
// Memory wait counter: cleared whenever no wait is in progress, counts
// each unacknowledged request cycle, and flags expiry on the LIMIT-th
// consecutive unacknowledged cycle (so a request is held for at most LIMIT
// cycles before the sequencer abandons it).
module cpu_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_r;

    // Wait-cycle counter: clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = inc && (count_r == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle Moore sequencer for the 16-bit CPU datapath. Shares one memory
// port and one ALU across fetch, address calculation, execute and branch.
// Optional multiplier support is enabled with the MULTICYCLE_MUL_EN macro;
// without it opcode 1000 is reported as illegal and executes as a NOP.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ack,
    input  logic       mul_done,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       mul_start,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [3:0] state
);

`ifdef MULTICYCLE_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    state_t state_r;
    state_t state_next_s;
    state_t instr_end_s;
    logic   bus_err_r;
    logic   mem_phase_s;
    logic   mem_wait_s;
    logic   wait_clr_s;
    logic   timeout_s;
    logic   legal_s;

    assign mem_phase_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
    assign mem_wait_s  = mem_phase_s && !mem_ack;
    assign wait_clr_s  = !mem_wait_s;
    assign legal_s     = opcode_legal(opcode, MUL_EN);
    assign bus_err     = bus_err_r;
    assign state       = state_r;

    cpu_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wait_clr_s),
        .inc    (mem_wait_s),
        .expire (timeout_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sticky bus-error flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= bus_err_r | timeout_s;
        end
    end

`ifdef MULTICYCLE_MUL_EN
    logic mul_busy_r;

    // Remembers that the multiplier was already started in this MUL visit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_busy_r <= 1'b0;
        end else begin
            mul_busy_r <= (state_r == S_MUL);
        end
    end
`else
    logic unused_mul_done_s;
    assign unused_mul_done_s = mul_done;
`endif

    // Where an instruction goes once it has completed.
    always_comb begin
        instr_end_s = S_IDLE;
        if (run) begin
            instr_end_s = S_FETCH;
        end else begin
            instr_end_s = S_IDLE;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (run && !bus_err_r) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_next_s = S_DECODE;
                end else if (timeout_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (!legal_s) begin
                    state_next_s = instr_end_s;
                end else begin
                    case (opcode)
                        OP_RTYPE:         state_next_s = S_EXEC_R;
                        OP_ADDI:          state_next_s = S_EXEC_I;
                        OP_LOAD, OP_STORE: state_next_s = S_ADDR;
                        OP_BEQ:           state_next_s = S_BRANCH;
                        OP_MUL:           state_next_s = MUL_EN ? S_MUL : instr_end_s;
                        default:          state_next_s = instr_end_s;
                    endcase
                end
            end
            S_EXEC_R: state_next_s = S_WB_ALU;
            S_EXEC_I: state_next_s = S_WB_ALU;
            S_ADDR: begin
                if (opcode == OP_STORE) begin
                    state_next_s = S_MEM_WR;
                end else begin
                    state_next_s = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    state_next_s = S_WB_MEM;
                end else if (timeout_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ack) begin
                    state_next_s = instr_end_s;
                end else if (timeout_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_MEM_WR;
                end
            end
            S_WB_ALU: state_next_s = instr_end_s;
            S_WB_MEM: state_next_s = instr_end_s;
            S_BRANCH: state_next_s = instr_end_s;
`ifdef MULTICYCLE_MUL_EN
            S_MUL: begin
                if (mul_done) begin
                    state_next_s = S_WB_ALU;
                end else begin
                    state_next_s = S_MUL;
                end
            end
`endif
            default: state_next_s = S_IDLE;
        endcase
    end

    // Datapath controls decoded from the current state. IR/PC loads in
    // FETCH are qualified by mem_ack so the PC advances exactly once.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_RT;
        alu_op     = ALUOP_ADD;
        mul_start  = 1'b0;
        illegal_op = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ALUB_TWO;
                ir_write  = mem_ack;
                pc_write  = mem_ack;
            end
            S_DECODE: begin
                alu_src_b  = ALUB_IMM;
                illegal_op = !legal_s;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                // ADDI adds the immediate to rs.
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_WB_ALU: begin
                // R-type and MUL write rd; ADDI writes rt.
                reg_write = 1'b1;
                reg_dst   = (opcode != OP_ADDI);
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 1'b1;
                pc_write  = alu_zero;
            end
`ifdef MULTICYCLE_MUL_EN
            S_MUL: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_MUL;
                mul_start = !mul_busy_r;
            end
`endif
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule
